calc_seq_32: RTL and testbench

Multi-cycle execute sequencer that sits directly downstream of the 8×32 register file and feeds its write port. It accepts one register-to-register instruction, drives the two read addresses, and captures both operands. It then computes the result, using a 32-iteration shift-add multiplier for MUL, and writes the result back through the register file's WE/Addr_W/Di port. It replaces hand-driven register-file control in the calculation experiments.

---
 rtl/calc_pkg.sv | 23 ++
 rtl/alu_core_32.sv | 41 ++++
 rtl/calc_seq_32.sv | 140 ++++++++++++++
 tb/tb_calc_seq_32.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared op-codes, FSM state encoding and multiplier iteration count for the
// calc_seq_32 execute sequencer.
package calc_pkg;

    localparam int unsigned MUL_ITER = 32;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_MOV = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_e;

endpackage

// File: rtl/alu_core_32.sv
// Combinational single-cycle ALU: ADD/SUB/AND/OR/XOR/SLT/MOV with signed overflow.
// MUL is iterated in the sequencer; this unit returns 0 for that code.
module alu_core_32
    import calc_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res,
    output logic        ovf
);

    logic [31:0] sum;
    logic [31:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (op)
            OP_ADD: begin
                res = sum;
                ovf = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            OP_SUB: begin
                res = diff;
                // Subtraction overflows like a + ~b: compare against the inverted sign of b.
                ovf = (a[31] == ~b[31]) && (diff[31] != a[31]);
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_SLT:  res = {31'b0, ($signed(a) < $signed(b))};
            OP_MOV:  res = a;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/calc_seq_32.sv
// Multi-cycle execute sequencer driving an 8x32 register file: IDLE -> READ -> EXEC -> WB.
// MUL runs as a 32-iteration shift-add loop inside EXEC.
module calc_seq_32
    import calc_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              cr,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] rd,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    output logic [ADDR_W-1:0] Addr_A,
    output logic [ADDR_W-1:0] Addr_B,
    input  logic [DATA_W-1:0] QA,
    input  logic [DATA_W-1:0] QB,
    output logic              WE,
    output logic [ADDR_W-1:0] Addr_W,
    output logic [DATA_W-1:0] Di,
    output logic              busy,
    output logic              done,
    output logic              zero,
    output logic              ovf
);

    localparam logic [4:0] CNT_LAST = 5'(MUL_ITER - 1);

    state_e            state_q, state_d;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] rd_q, ra_q, rb_q;
    logic [DATA_W-1:0] a_q, b_q, r_q;
    logic [4:0]        cnt_q;
    logic              ovf_calc_q;
    logic              zero_q, ovf_q;

    logic [DATA_W-1:0] alu_res;
    logic              alu_ovf;

    alu_core_32 u_alu (
        .op  (op_q),
        .a   (a_q),
        .b   (b_q),
        .res (alu_res),
        .ovf (alu_ovf)
    );

    always_ff @(posedge clk or negedge cr) begin
        if (!cr) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_READ;
            S_READ: state_d = S_EXEC;
            S_EXEC: begin
                if (op_q != OP_MUL || cnt_q == CNT_LAST) state_d = S_WB;
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge cr) begin
        if (!cr) begin
            op_q       <= '0;
            rd_q       <= '0;
            ra_q       <= '0;
            rb_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            r_q        <= '0;
            cnt_q      <= '0;
            ovf_calc_q <= 1'b0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q <= op;
                        rd_q <= rd;
                        ra_q <= ra;
                        rb_q <= rb;
                    end
                end
                S_READ: begin
                    a_q   <= QA;
                    b_q   <= QB;
                    r_q   <= '0;
                    cnt_q <= '0;
                end
                S_EXEC: begin
                    if (op_q == OP_MUL) begin
                        if (b_q[0]) r_q <= r_q + a_q;
                        a_q   <= a_q << 1;
                        b_q   <= b_q >> 1;
                        cnt_q <= cnt_q + 5'd1;
                    end else begin
                        r_q        <= alu_res;
                        ovf_calc_q <= alu_ovf;
                    end
                end
                S_WB: begin
                    zero_q <= (r_q == '0);
                    ovf_q  <= (op_q == OP_ADD || op_q == OP_SUB) ? ovf_calc_q : 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Strobes decode from state only, so no input reaches them combinationally.
    always_comb begin
        WE     = 1'b0;
        done   = 1'b0;
        busy   = (state_q != S_IDLE);
        Addr_W = '0;
        Di     = '0;
        if (state_q == S_WB) begin
            WE     = 1'b1;
            done   = 1'b1;
            Addr_W = rd_q;
            Di     = r_q;
        end
    end

    assign Addr_A = ra_q;
    assign Addr_B = rb_q;
    assign zero   = zero_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_calc_seq_32.sv
// Self-checking bench for calc_seq_32: register-file model plus an arithmetic
// reference, directed cases followed by randomized instruction streams.
module tb_calc_seq_32;
    import calc_pkg::*;

    logic        clk;
    logic        cr;
    logic        start;
    logic [2:0]  op, rd, ra, rb;
    logic [2:0]  Addr_A, Addr_B, Addr_W;
    logic [31:0] QA, QB, Di;
    logic        WE, busy, done, zero, ovf;

    logic [31:0] rf [8];
    logic        ld_we;
    logic [2:0]  ld_addr;
    logic [31:0] ld_data;

    logic [31:0] mrf [8];
    logic        zm, om;

    int n_cmp;
    int n_err;

    calc_seq_32 dut (
        .clk    (clk),
        .cr     (cr),
        .start  (start),
        .op     (op),
        .rd     (rd),
        .ra     (ra),
        .rb     (rb),
        .Addr_A (Addr_A),
        .Addr_B (Addr_B),
        .QA     (QA),
        .QB     (QB),
        .WE     (WE),
        .Addr_W (Addr_W),
        .Di     (Di),
        .busy   (busy),
        .done   (done),
        .zero   (zero),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign QA = rf[Addr_A];
    assign QB = rf[Addr_B];

    always @(posedge clk) begin
        if (WE) rf[Addr_W] <= Di;
        else if (ld_we) rf[ld_addr] <= ld_data;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, result} from plain arithmetic on the operand values.
    function automatic logic [32:0] ref_exec(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
        longint s;
        logic [63:0] p;
        logic [31:0] r;
        logic v;
        v = 1'b0;
        case (o)
            OP_ADD: begin
                r = a + b;
                s = longint'($signed(a)) + longint'($signed(b));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_SUB: begin
                r = a - b;
                s = longint'($signed(a)) - longint'($signed(b));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_SLT: r = (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
            OP_MUL: begin
                p = 64'(a) * 64'(b);
                r = p[31:0];
            end
            default: r = a;
        endcase
        return {v, r};
    endfunction

    task automatic load(input logic [2:0] idx, input logic [31:0] v);
        ld_we   = 1'b1;
        ld_addr = idx;
        ld_data = v;
        @(posedge clk);
        #1;
        ld_we    = 1'b0;
        mrf[idx] = v;
    endtask

    // Issue one instruction and follow it through write-back. With glitch set,
    // start stays high with junk fields while busy.
    task automatic exec(input logic [2:0] op_v, input logic [2:0] rd_v, input logic [2:0] ra_v,
                        input logic [2:0] rb_v, input bit glitch);
        logic [32:0] e;
        int          lat;
        int          cyc;
        e   = ref_exec(op_v, mrf[ra_v], mrf[rb_v]);
        lat = (op_v == OP_MUL) ? 34 : 3;
        start = 1'b1;
        op    = op_v;
        rd    = rd_v;
        ra    = ra_v;
        rb    = rb_v;
        @(posedge clk);
        #1;
        if (glitch) begin
            op = 3'($urandom);
            rd = 3'($urandom);
            ra = 3'($urandom);
            rb = 3'($urandom);
        end else begin
            start = 1'b0;
        end
        cyc = 1;
        check_eq("busy_c1", 64'(busy), 64'd1);
        while (!done && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        check_eq("latency", 64'(cyc), 64'(lat));
        check_eq("we", 64'(WE), 64'd1);
        check_eq("addr_w", 64'(Addr_W), 64'(rd_v));
        check_eq("di", 64'(Di), 64'(e[31:0]));
        @(posedge clk);
        #1;
        mrf[rd_v] = e[31:0];
        zm = (e[31:0] == 32'd0);
        om = (op_v == OP_ADD || op_v == OP_SUB) ? e[32] : 1'b0;
        check_eq("rf_commit", 64'(rf[rd_v]), 64'(mrf[rd_v]));
        check_eq("zero", 64'(zero), 64'(zm));
        check_eq("ovf", 64'(ovf), 64'(om));
        check_eq("idle_after", 64'({busy, done, WE}), 64'd0);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'h7FFF_FFFF;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int we_seen;
        n_cmp = 0;
        n_err = 0;
        cr    = 1'b0;
        start = 1'b0;
        op    = '0;
        rd    = '0;
        ra    = '0;
        rb    = '0;
        ld_we = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        zm = 1'b0;
        om = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outs", 64'({WE, Addr_W, Addr_A, Addr_B, Di, busy, done, zero, ovf}),
                 64'd0);
        cr = 1'b1;

        for (int i = 0; i < 8; i++) load(3'(i), $urandom);

        // Directed cases
        load(3'd1, 32'd5);
        load(3'd2, 32'd7);
        exec(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0);
        load(3'd1, 32'h8000_0000);
        load(3'd2, 32'd1);
        exec(OP_SUB, 3'd3, 3'd1, 3'd2, 1'b0);
        exec(OP_SUB, 3'd3, 3'd1, 3'd1, 1'b0);
        load(3'd4, 32'h0001_0003);
        load(3'd5, 32'h0000_0010);
        exec(OP_MUL, 3'd6, 3'd4, 3'd5, 1'b0);
        load(3'd1, 32'hFFFF_FFFF);
        load(3'd2, 32'd2);
        exec(OP_MUL, 3'd7, 3'd1, 3'd2, 1'b0);
        load(3'd2, 32'd1);
        exec(OP_SLT, 3'd3, 3'd1, 3'd2, 1'b0);
        exec(OP_SLT, 3'd3, 3'd2, 3'd1, 1'b0);
        exec(OP_MOV, 3'd7, 3'd2, 3'd0, 1'b0);
        // start held through busy, then back-to-back reader of the new R1
        exec(OP_ADD, 3'd1, 3'd1, 3'd2, 1'b1);
        exec(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0);
        exec(OP_XOR, 3'd1, 3'd3, 3'd3, 1'b0);

        // Reset in the middle of a MUL
        start = 1'b1;
        op    = OP_MUL;
        rd    = 3'd6;
        ra    = 3'd4;
        rb    = 3'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        cr = 1'b0;
        #1;
        check_eq("rst_mid_outs", 64'({WE, Addr_W, Addr_A, Addr_B, Di, busy, done, zero, ovf}),
                 64'd0);
        zm = 1'b0;
        om = 1'b0;
        @(posedge clk);
        #1;
        cr = 1'b1;
        we_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (WE) we_seen++;
        end
        check_eq("no_we_after_rst", 64'(we_seen), 64'd0);
        check_eq("rf6_kept", 64'(rf[6]), 64'(mrf[6]));
        check_eq("flags_after_rst", 64'({zero, ovf}), 64'd0);

        // Start accepted on the first edge after reset release
        cr = 1'b0;
        @(posedge clk);
        #1;
        cr = 1'b1;
        exec(OP_OR, 3'd0, 3'd4, 3'd5, 1'b0);

        // Randomized stream
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) load(3'($urandom), pick_val());
            exec(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                 ($urandom_range(0, 4) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
